// File: rtl/morse_pkg.sv
// Shared state encoding and Morse timing constants for the symbol sequencer.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SPACE,
    CHAR_GAP
  } state_t;

  localparam int DOT_UNITS      = 1;
  localparam int DASH_UNITS     = 3;
  localparam int ELEM_GAP_UNITS = 1;
  localparam int CHAR_GAP_UNITS = 3;
  localparam int MAX_ELEMS      = 5;
  localparam int LEN_W          = 3;

endpackage

// File: rtl/morse_unit_timer.sv
// Unit-time prescaler: unit_tick marks the last cycle of each Morse time unit.
module morse_unit_timer #(
  parameter int UNIT_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  output logic unit_tick
);

  localparam int CNT_W = $clog2(UNIT_CYCLES);

  logic [CNT_W-1:0] cnt;

  assign unit_tick = (cnt == CNT_W'(UNIT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      cnt <= '0;
    end else if (unit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/morse_symbol_sequencer.sv
// Keys one Morse character (dot/dash elements, LSB first) onto a registered output line.
module morse_symbol_sequencer #(
  parameter int UNIT_CYCLES = 4,
  parameter int MAX_ELEMS   = 5
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          START,
  input  logic [MAX_ELEMS-1:0]          SYM_PATTERN,
  input  logic [morse_pkg::LEN_W-1:0]   SYM_LEN,
  output logic                          MORSE_OUT,
  output logic                          BUSY,
  output logic                          DONE
);

  import morse_pkg::*;

  state_t                 state, state_next;
  logic [MAX_ELEMS-1:0]   pattern_q;
  logic [LEN_W-1:0]       len_q;
  logic [2:0]             idx;
  logic [1:0]             unit_cnt;
  logic                   unit_tick;
  logic                   unit_done;
  logic                   timer_clear;
  logic                   len_ok;
  logic                   idle_entry_p0;

  function automatic logic [1:0] last_unit(input state_t s, input logic dash);
    logic [1:0] r;
    r = 2'd0;
    case (s)
      MARK:     r = dash ? 2'(DASH_UNITS - 1) : 2'(DOT_UNITS - 1);
      SPACE:    r = 2'(ELEM_GAP_UNITS - 1);
      CHAR_GAP: r = 2'(CHAR_GAP_UNITS - 1);
      default:  r = 2'd0;
    endcase
    return r;
  endfunction

  assign len_ok    = (SYM_LEN != '0) && (int'(SYM_LEN) <= MAX_ELEMS);
  assign unit_done = unit_tick && (unit_cnt == last_unit(state, pattern_q[idx]));
  // Holding the prescaler cleared in IDLE and on every transition makes each state exact.
  assign timer_clear = (state_next != state) || (state == IDLE);

  morse_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (timer_clear),
    .unit_tick(unit_tick)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (START && len_ok) state_next = MARK;
      MARK:     if (unit_done) state_next = ((idx + 3'd1) < len_q) ? SPACE : CHAR_GAP;
      SPACE:    if (unit_done) state_next = MARK;
      CHAR_GAP: if (unit_done) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pattern_q     <= '0;
      len_q         <= '0;
      idx           <= '0;
      unit_cnt      <= '0;
      idle_entry_p0 <= 1'b0;
      MORSE_OUT     <= 1'b0;
      BUSY          <= 1'b0;
      DONE          <= 1'b0;
    end else begin
      if (state == IDLE && state_next == MARK) begin
        pattern_q <= SYM_PATTERN;
        len_q     <= SYM_LEN;
        idx       <= '0;
      end else if (state == SPACE && state_next == MARK) begin
        idx <= idx + 3'd1;
      end

      if (timer_clear) begin
        unit_cnt <= '0;
      end else if (unit_tick) begin
        unit_cnt <= unit_cnt + 2'd1;
      end

      // Outputs are registered views of the current state, one cycle behind it.
      idle_entry_p0 <= (state == CHAR_GAP) && (state_next == IDLE);
      MORSE_OUT     <= (state == MARK);
      BUSY          <= (state != IDLE);
      DONE          <= idle_entry_p0;
    end
  end

endmodule

// File: doc/morse_symbol_sequencer.md
Name: morse_symbol_sequencer

Overview:
Sequences one Morse character (up to 5 dot/dash elements) onto a single keyed output line, using standard Morse timing: dot = 1 unit, dash = 3 units, intra-character gap = 1 unit, trailing inter-character gap = 3 units. It sits between the character encoder/lookup and the output driver (LED/buzzer). It owns the unit-time prescaler and the element/unit counters. It accepts one character per START handshake and pulses DONE when the character, including its trailing gap, is complete.

Parameters:
UNIT_CYCLES, 4, clock cycles per Morse time unit (≥2; 4 for simulation, board value set at top level)
MAX_ELEMS, 5, maximum elements per character (letters and digits)

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous, active-high reset
START  input  1  request to send; sampled only in IDLE
SYM_PATTERN  input  5  element codes, LSB sent first; 1 = dash, 0 = dot
SYM_LEN  input  3  number of valid elements, legal range 1..5
MORSE_OUT  output  1  keyed line, registered; 1 = tone/mark
BUSY  output  1  high from the cycle after an accepted START until DONE
DONE  output  1  one-cycle pulse at character completion

Behaviour:
- Reset (synchronous; RST high at a rising edge): state = IDLE; MORSE_OUT = 0, BUSY = 0, DONE = 0; all counters and latched pattern/len cleared. Applies mid-character: the output drops at that same edge and no DONE is issued.
- States:
  - IDLE
  - MARK: MORSE_OUT = 1
  - SPACE: 1-unit intra-character gap, MORSE_OUT = 0
  - CHAR_GAP: 3-unit trailing gap, MORSE_OUT = 0
- Accept: in IDLE with START = 1 and 1 ≤ SYM_LEN ≤ 5, latch SYM_PATTERN/SYM_LEN, set element index to 0, and enter MARK on the next edge. MORSE_OUT and BUSY rise 1 cycle after START.
- Illegal SYM_LEN (0, 6, 7): START is ignored; stay in IDLE; no BUSY, no DONE.
- START while BUSY: ignored. Input changes after acceptance: no effect.
- MARK lasts 1×UNIT_CYCLES cycles (dot) or 3×UNIT_CYCLES cycles (dash).
  - Then go to SPACE if index < len−1, otherwise go to CHAR_GAP.
- SPACE lasts UNIT_CYCLES cycles, then increments the index and returns to MARK.
- CHAR_GAP lasts 3×UNIT_CYCLES cycles, then returns to IDLE.
  - In the IDLE-entry cycle: DONE = 1 for exactly 1 cycle, BUSY = 0.
- Back-to-back: START asserted in the same cycle as DONE is accepted, so MARK starts the next cycle with no extra gap.
- Timing counters:
  - Prescaler counts 0..UNIT_CYCLES−1 and produces a unit_tick on the terminal count.
  - Prescaler is cleared on every state entry so every state duration is exact.
  - Unit counter is 2 bits (counts to 3). Element index is 3 bits.
- Outputs are glitch-free registers; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package (morse_pkg):
  - state enum {IDLE, MARK, SPACE, CHAR_GAP}
  - constants DOT_UNITS = 1, DASH_UNITS = 3, ELEM_GAP_UNITS = 1, CHAR_GAP_UNITS = 3, MAX_ELEMS = 5
  - SYM_LEN width (3)
- One natural sub-module: morse_unit_timer.
  - Inputs: CLK, RST, clear. Output: unit_tick.
  - Contains the parameterised UNIT_CYCLES prescaler.
  - Same enable/reset counter style as the team's existing counters.

Test Plan (UNIT_CYCLES = 4; cycle 0 = edge where START is sampled):
- "E": SYM_LEN = 1, SYM_PATTERN = 00000, START pulse → MORSE_OUT = 1 on cycles 1–4, 0 on cycles 5–16; DONE = 1 on cycle 17 only; BUSY high on cycles 1–16.
- "A": SYM_LEN = 2, SYM_PATTERN = 00010 → MORSE_OUT high 1–4, low 5–8, high 9–20, low 21–32; DONE on cycle 33.
- Illegal length: SYM_LEN = 0, then 6, each with START → MORSE_OUT, BUSY and DONE stay 0 for 40 cycles.
- Busy/back-to-back: second START at cycle 10 of "A" is ignored; START held high through DONE (cycle 33) is accepted → MORSE_OUT rises on cycle 34.
- Reset mid-character: RST = 1 at cycle 11 of "A" → MORSE_OUT = 0 and BUSY = 0 from that edge, state IDLE, no DONE; a subsequent "E" then runs with the exact timing above.
- "0" (5 dashes): SYM_LEN = 5, SYM_PATTERN = 11111 → five 12-cycle marks separated by 4-cycle gaps, then a 12-cycle gap; DONE on cycle 1 + 5·12 + 4·4 + 12 = 89.
